rs232_cmd_ctrl: RTL

Command-frame controller that sits directly behind the RS-232 byte receiver. It converts the receiver's "byte valid" level into single-cycle byte strobes in the system clock domain, and parses a fixed 4-byte write-command frame. It then checks the frame, commits valid writes into a small local register bank, and reports frame errors. Host software configures downstream blocks through this register bank over the serial link.

---
 rtl/rs232_cmd_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/rs232_cmd_ctrl.sv
// Command-frame controller behind the RS-232 byte receiver: synchronises the
// byte-valid level and turns SYNC,ADDR,DATA,SUM frames into register writes.
module rs232_cmd_ctrl #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int          NREG    = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ctrl,
  input  logic [7:0]        rx_data,
  output logic [8*NREG-1:0] reg_q,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              cmd_ok,
  output logic              cmd_err,
  output logic [1:0]        err_code,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_ADDR, GOT_DATA} state_t;

  localparam logic [7:0] NREG8 = 8'(NREG);

  state_t      state;
  logic        s1, s2, s3;
  logic [7:0]  addr, data;
  logic [15:0] tcnt;
  logic        ev, tmo, fail, wr;
  logic [1:0]  code;
  logic [7:0]  sum;

  assign ev  = s2 & ~s3;
  assign sum = SYNC ^ addr ^ data;
  // A byte arriving on the expiry cycle keeps the frame alive.
  assign tmo = ~ev && (state != IDLE) && (tcnt == TIMEOUT - 16'd1);

  always_comb begin
    fail = 1'b0;
    wr   = 1'b0;
    code = 2'd0;
    if (ev && state == GOT_DATA) begin
      if (rx_data != sum) begin
        fail = 1'b1;
        code = 2'd1;
      end else if (addr >= NREG8) begin
        fail = 1'b1;
        code = 2'd2;
      end else begin
        wr = 1'b1;
      end
    end else if (tmo) begin
      fail = 1'b1;
      code = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Sync chain loads 1 so a level already high at release is not a byte.
      {s3, s2, s1} <= 3'b111;
      state    <= IDLE;
      tcnt     <= '0;
      addr     <= '0;
      data     <= '0;
      reg_q    <= '0;
      wr_en    <= 1'b0;
      cmd_ok   <= 1'b0;
      cmd_err  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err_code <= '0;
      err_cnt  <= '0;
    end else begin
      {s3, s2, s1} <= {s2, s1, rx_ctrl};
      tcnt    <= (ev || state == IDLE) ? 16'd0 : tcnt + 16'd1;
      wr_en   <= wr;
      cmd_ok  <= wr;
      cmd_err <= fail;
      if (fail) begin
        err_code <= code;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
      if (wr) begin
        wr_addr <= addr[3:0];
        wr_data <= data;
        for (int i = 0; i < NREG; i++)
          if (addr == 8'(i)) reg_q[8*i +: 8] <= data;
      end
      if (tmo) begin
        state <= IDLE;
      end else if (ev) begin
        case (state)
          IDLE:     if (rx_data == SYNC) state <= GOT_SYNC;
          GOT_SYNC: begin addr <= rx_data; state <= GOT_ADDR; end
          GOT_ADDR: begin data <= rx_data; state <= GOT_DATA; end
          GOT_DATA: state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule
